// File: rtl/count_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : count_sample_fifo
//  Description : Small register-file FIFO that buffers counter samples between
//                a free-running counter and a downstream consumer. Samples are
//                captured on in_valid_i && in_ready_o. They are presented in
//                order on a valid/ready port whose data is registered.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   1         rising-edge clock
//    rst           in   1         asynchronous active-high reset
//    in_valid_i    in   1         upstream sample valid
//    in_data_i     in   DATA_W    upstream sample
//    in_ready_o    out  1         storage not full (derived from registered
//                                 pointers only; no path from out_ready_i)
//    out_valid_o   out  1         out_data_o holds a valid sample
//    out_data_o    out  DATA_W    oldest sample, registered
//    out_ready_i   in   1         downstream accepts the sample
//    level_o       out  ADDR_W+1  entries in storage plus output register
//    overflow_o    out  1         sticky: a sample was offered while full
//    drop_count_o  out  8         (COUNT_FIFO_DROPCNT_EN only) saturating
//                                 count of discarded samples
//  Build option
//    COUNT_FIFO_DROPCNT_EN : adds drop_count_o and its counter.
// ============================================================================
module count_sample_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i,
    output logic [ADDR_W:0]   level_o,
`ifdef COUNT_FIFO_DROPCNT_EN
    output logic              overflow_o,
    output logic [7:0]        drop_count_o
`else
    output logic              overflow_o
`endif
);

    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    // Storage is deliberately not reset; the pointers define what is valid.
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              overflow_q, overflow_d;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_slot;
    logic w_drop;

    // The extra wrap bit separates full from empty when the low bits match.
    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                     (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

    assign w_push = in_valid_i && !w_full;
    assign w_drop = in_valid_i && w_full;
    assign w_pop  = out_valid_q && out_ready_i;
    // The output register can take a new sample if it is idle or drains now.
    assign w_slot = !out_valid_q || w_pop;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        if (w_slot) begin
            if (!w_empty) begin
                out_data_d  = mem_q[rd_ptr_q[ADDR_W-1:0]];
                rd_ptr_d    = rd_ptr_q + PTR_ONE;
                out_valid_d = 1'b1;
            end else if (w_push) begin
                // Fall-through: the sample is still written to storage and
                // both pointers step, so storage stays empty while the output
                // register takes the incoming sample directly.
                out_data_d  = in_data_i;
                rd_ptr_d    = rd_ptr_q + PTR_ONE;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end

        level_d    = (wr_ptr_d - rd_ptr_d) + {{ADDR_W{1'b0}}, out_valid_d};
        overflow_d = overflow_q | w_drop;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= in_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef COUNT_FIFO_DROPCNT_EN
    logic [7:0] drop_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_count_q <= 8'h00;
        end else if (w_drop && (drop_count_q != 8'hFF)) begin
            drop_count_q <= drop_count_q + 8'd1;
        end
    end

    assign drop_count_o = drop_count_q;
`endif

    assign in_ready_o  = !w_full;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign level_o     = level_q;
    assign overflow_o  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_count_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_sample_fifo
//  Description : Self-checking bench for count_sample_fifo. A queue-based
//                reference model holds every buffered sample, including the
//                one shown on the output port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_count_sample_fifo;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready = 1'b0;
    logic [ADDR_W:0]   level;
    logic              overflow;
`ifdef COUNT_FIFO_DROPCNT_EN
    logic [7:0]        drop_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: all buffered samples, oldest first.
    logic [DATA_W-1:0] mq[$];
    bit                m_ovf;
    int                m_drops;

    always #5 clk = ~clk;

    count_sample_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_ready_o   (in_ready),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .out_ready_i  (out_ready),
        .level_o      (level),
`ifdef COUNT_FIFO_DROPCNT_EN
        .overflow_o   (overflow),
        .drop_count_o (drop_count)
`else
        .overflow_o   (overflow)
`endif
    );

    // Advance one clock; the model accepts while total content <= DEPTH
    // (storage not full) and pops whenever anything is buffered.
    task automatic step();
        bit acc;
        acc = in_valid && (mq.size() <= DEPTH);
        if (in_valid && !acc) begin
            m_ovf = 1'b1;
            if (m_drops < 255) m_drops++;
        end
        if (out_ready && mq.size() > 0) void'(mq.pop_front());
        if (acc) mq.push_back(in_data);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        m_ovf   = 1'b0;
        m_drops = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic push_n(input int n, input int first);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = 4'(first + i);
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++; if (level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
        n_checks++; if (out_data !== 4'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
        // Mid-stream reset with three samples held.
        push_n(3, 7);
        n_checks++; if (level !== 3'd3) begin n_fail++; $display("FAIL pre_rst_level got %0d want 3", level); end
        rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0 || level !== 3'd0 || in_ready !== 1'b1 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got v=%b lvl=%0d rdy=%b ovf=%b want 0 0 1 0", out_valid, level, in_ready, overflow);
        end
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        m_drops = 0;
        @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_stale got v=%b want 0", out_valid); end
        push_n(1, 9);
        out_ready = 1'b1;
        n_checks++; if (out_valid !== 1'b1 || out_data !== 4'h9) begin n_fail++; $display("FAIL post_rst_data got v=%b d=%h want 1 9", out_valid, out_data); end
        step();
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL post_rst_drain got v=%b lvl=%0d want 0 0", out_valid, level); end
    endtask

    task automatic test_latency();
        do_reset();
        push_n(1, 5);
        n_checks++; if (out_valid !== 1'b1 || out_data !== 4'h5) begin n_fail++; $display("FAIL latency got v=%b d=%h want 1 5", out_valid, out_data); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (out_valid !== 1'b1 || out_data !== 4'h5) begin n_fail++; $display("FAIL hold_%0d got v=%b d=%h want 1 5", i, out_valid, out_data); end
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL latency_pop got v=%b lvl=%0d want 0 0", out_valid, level); end
    endtask

    task automatic test_fill_order();
        do_reset();
        push_n(5, 1);
        n_checks++; if (level !== 3'd5) begin n_fail++; $display("FAIL fill_level got %0d want 5", level); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready got %b want 0", in_ready); end
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_data !== 4'(i) || level !== 3'(6 - i)) begin
                n_fail++; $display("FAIL drain_%0d got v=%b d=%h lvl=%0d want 1 %h %0d", i, out_valid, out_data, level, 4'(i), 6 - i);
            end
            step();
        end
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL drained got v=%b lvl=%0d want 0 0", out_valid, level); end
    endtask

    task automatic test_overflow();
        do_reset();
        push_n(5, 1);
        in_valid = 1'b1;
        in_data  = 4'hA;
        step();
        in_valid = 1'b0;
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL overflow_set got %b want 1", overflow); end
`ifdef COUNT_FIFO_DROPCNT_EN
        n_checks++; if (drop_count !== 8'd1) begin n_fail++; $display("FAIL drop_count_one got %0d want 1", drop_count); end
`endif
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            n_checks++; if (out_data !== 4'(i) || out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_drain_%0d got v=%b d=%h want 1 %h", i, out_valid, out_data, 4'(i)); end
            step();
        end
        n_checks++; if (out_valid !== 1'b0 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got v=%b ovf=%b want 0 1", out_valid, overflow); end
`ifdef COUNT_FIFO_DROPCNT_EN
        out_ready = 1'b0;
        push_n(5, 1);
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) step();
        in_valid = 1'b0;
        n_checks++; if (drop_count !== 8'hFF) begin n_fail++; $display("FAIL drop_count_sat got %h want ff", drop_count); end
`endif
        out_ready = 1'b0;
    endtask

    task automatic test_streaming();
        do_reset();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = 4'(i);
            step();
            n_checks++; if (out_valid !== 1'b1 || out_data !== 4'(i) || level !== 3'd1 || overflow !== 1'b0) begin
                n_fail++; $display("FAIL stream_%0d got v=%b d=%h lvl=%0d ovf=%b want 1 %h 1 0", i, out_valid, out_data, level, overflow, 4'(i));
            end
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        do_reset();
        push_n(5, 1);
        in_valid  = 1'b1;
        in_data   = 4'h6;
        out_ready = 1'b1;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_refuse got %b want 0", in_ready); end
        step();
        out_ready = 1'b0;
        n_checks++; if (in_ready !== 1'b1 || overflow !== 1'b1 || level !== 3'd4) begin
            n_fail++; $display("FAIL full_pop_next got rdy=%b ovf=%b lvl=%0d want 1 1 4", in_ready, overflow, level);
        end
        step();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 2; i <= 6; i++) begin
            n_checks++; if (out_valid !== 1'b1 || out_data !== 4'(i)) begin n_fail++; $display("FAIL full_pop_drain_%0d got v=%b d=%h want 1 %h", i, out_valid, out_data, 4'(i)); end
            step();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 4'($urandom);
            out_ready = ($urandom_range(0, 2) == 0);
            step();
            n_checks++;
            if (out_valid !== (mq.size() > 0) || level !== 3'(mq.size()) || in_ready !== (mq.size() <= DEPTH) ||
                overflow !== m_ovf || (mq.size() > 0 && out_data !== mq[0])) begin
                n_fail++;
                $display("FAIL random_%0d got v=%b d=%h lvl=%0d rdy=%b ovf=%b want v=%b d=%h lvl=%0d rdy=%b ovf=%b", c,
                         out_valid, out_data, level, in_ready, overflow, mq.size() > 0,
                         (mq.size() > 0) ? mq[0] : 4'h0, mq.size(), mq.size() <= DEPTH, m_ovf);
            end
`ifdef COUNT_FIFO_DROPCNT_EN
            n_checks++; if (drop_count !== 8'(m_drops)) begin n_fail++; $display("FAIL random_drops_%0d got %0d want %0d", c, drop_count, m_drops); end
`endif
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill_order();
        test_overflow();
        test_streaming();
        test_full_pop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
